// File: rtl/if_id_skid_stage.sv
// Elastic IF/ID stage boundary: valid/ready handshake with an optional skid entry,
// synchronous flush that inserts a bubble, and a saturating flush-drop counter.
module if_id_skid_stage #(
   parameter int                DATA_W = 96,
   parameter logic [DATA_W-1:0] BUBBLE = 96'h00000000_00000013_00000004,
   parameter bit                SKID   = 1'b1,
   parameter int                CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_flush,
   input  logic              i_in_valid,
   input  logic [DATA_W-1:0] i_in_data,
   output logic              o_in_ready,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   input  logic              i_out_ready,
   output logic [CNT_W-1:0]  o_drop_cnt
);

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [1:0]       b);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
      return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction

   logic              out_vld_p0, skid_vld_p0;
   logic [DATA_W-1:0] out_data_p0, skid_data_p0;
   logic [CNT_W-1:0]  drop_cnt;

   logic in_fire, out_fire, load_out;
   logic out_from_skid, out_from_in, skid_from_in;
   logic out_vld_nxt, skid_vld_nxt;
   logic [1:0] drop;

   // With SKID the ready comes straight from a flop; without it, ready looks through.
   assign o_in_ready = SKID ? ~skid_vld_p0 : (~out_vld_p0 | i_out_ready);
   assign in_fire    = i_in_valid & o_in_ready;
   assign out_fire   = out_vld_p0 & i_out_ready;

   always_comb begin
      load_out      = ~out_vld_p0 | out_fire;
      out_from_skid = load_out & skid_vld_p0;
      out_from_in   = load_out & ~skid_vld_p0 & in_fire;
      skid_from_in  = in_fire & (~load_out | skid_vld_p0);
      out_vld_nxt   = load_out ? (skid_vld_p0 | in_fire) : out_vld_p0;
      skid_vld_nxt  = skid_from_in | (skid_vld_p0 & ~load_out);
      // An entry leaving downstream in the flush cycle is delivered, not dropped.
      drop = {1'b0, out_vld_p0 & ~i_out_ready} + {1'b0, skid_vld_p0} + {1'b0, in_fire};
   end

   // Control stage: valids and drop counter
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         out_vld_p0  <= 1'b0;
         skid_vld_p0 <= 1'b0;
         drop_cnt    <= '0;
      end else if (i_flush) begin
         out_vld_p0  <= 1'b0;
         skid_vld_p0 <= 1'b0;
         drop_cnt    <= sat_add(drop_cnt, drop);
      end else begin
         out_vld_p0  <= out_vld_nxt;
         skid_vld_p0 <= skid_vld_nxt;
      end
   end

   // Data stage: payload registers, qualified by the valids above
   always_ff @(posedge i_clk) begin
      if (out_from_skid)
         out_data_p0 <= skid_data_p0;
      else if (out_from_in)
         out_data_p0 <= i_in_data;
      if (skid_from_in)
         skid_data_p0 <= i_in_data;
   end

   assign o_valid    = out_vld_p0;
   assign o_data     = out_vld_p0 ? out_data_p0 : BUBBLE;
   assign o_drop_cnt = drop_cnt;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed bench for if_id_skid_stage: SKID=1, SKID=0 and a CNT_W=2 instance
// driven from shared inputs, checked against hand-computed expectations.
module tb_if_id_skid_stage;

   localparam int          DW     = 96;
   localparam logic [95:0] BUBBLE = 96'h00000000_00000013_00000004;

   logic          clk, rst, flush, in_valid, out_ready;
   logic [DW-1:0] in_data;

   logic          rdy_s, vld_s, rdy_r, vld_r, rdy_c, vld_c;
   logic [DW-1:0] dat_s, dat_r, dat_c;
   logic [15:0]   cnt_s, cnt_r;
   logic [1:0]    cnt_c;

   int errors = 0;
   int checks = 0;

   if_id_skid_stage #(.DATA_W(DW), .BUBBLE(BUBBLE), .SKID(1'b1), .CNT_W(16)) u_skid (
      .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(in_valid), .i_in_data(in_data),
      .o_in_ready(rdy_s), .o_valid(vld_s), .o_data(dat_s), .i_out_ready(out_ready),
      .o_drop_cnt(cnt_s));

   if_id_skid_stage #(.DATA_W(DW), .BUBBLE(BUBBLE), .SKID(1'b0), .CNT_W(16)) u_reg (
      .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(in_valid), .i_in_data(in_data),
      .o_in_ready(rdy_r), .o_valid(vld_r), .o_data(dat_r), .i_out_ready(out_ready),
      .o_drop_cnt(cnt_r));

   if_id_skid_stage #(.DATA_W(DW), .BUBBLE(BUBBLE), .SKID(1'b1), .CNT_W(2)) u_sat (
      .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(in_valid), .i_in_data(in_data),
      .o_in_ready(rdy_c), .o_valid(vld_c), .o_data(dat_c), .i_out_ready(out_ready),
      .o_drop_cnt(cnt_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [95:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      #2;
      check("rst_vld", {95'b0, vld_s}, 96'd0);
      check("rst_data", dat_s, BUBBLE);
      check("rst_rdy", {95'b0, rdy_s}, 96'd1);
      check("rst_cnt", {80'b0, cnt_s}, 96'd0);
      #10;
      rst = 1'b0;
      tick();

      // Streaming on both variants
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1;
         in_data  = 96'(i);
         #1;
         check("stream_rdy_skid", {95'b0, rdy_s}, 96'd1);
         check("stream_rdy_reg", {95'b0, rdy_r}, 96'd1);
         tick();
         check("stream_skid", {95'b0, vld_s} << 95 | dat_s, (96'd1 << 95) | 96'(i));
         check("stream_reg", {95'b0, vld_r} << 95 | dat_r, (96'd1 << 95) | 96'(i));
      end
      in_valid = 1'b0;
      tick();
      check("stream_end_skid", dat_s, BUBBLE);
      check("stream_end_reg", dat_r, BUBBLE);
      check("stream_end_vld", {94'b0, vld_s, vld_r}, 96'd0);

      // Back-pressure on the skid variant
      out_ready = 1'b0;
      push(96'hA);
      check("bp_a_out", dat_s, 96'hA);
      check("bp_a_rdy", {95'b0, rdy_s}, 96'd1);
      push(96'hB);
      check("bp_b_out", dat_s, 96'hA);
      check("bp_b_rdy", {95'b0, rdy_s}, 96'd0);
      in_valid = 1'b0;
      tick();
      check("bp_hold_out", dat_s, 96'hA);
      check("bp_hold_rdy", {95'b0, rdy_s}, 96'd0);
      out_ready = 1'b1;
      tick();
      check("bp_rel_out", dat_s, 96'hB);
      check("bp_rel_rdy", {95'b0, rdy_s}, 96'd1);
      tick();
      check("bp_drain_vld", {95'b0, vld_s}, 96'd0);
      check("bp_drain_data", dat_s, BUBBLE);

      // Flush with output and skid full; upstream valid but not accepted -> drops 2
      out_ready = 1'b0;
      push(96'hC);
      push(96'hD);
      check("fl_full_rdy", {95'b0, rdy_s}, 96'd0);
      in_valid = 1'b1; in_data = 96'hE; flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("fl_full_vld", {95'b0, vld_s}, 96'd0);
      check("fl_full_data", dat_s, BUBBLE);
      check("fl_full_cnt", {80'b0, cnt_s}, 96'd2);
      check("fl_full_rdy2", {95'b0, rdy_s}, 96'd1);

      // Flush with output held and an accepted input -> drops 2 more
      push(96'hF);
      in_valid = 1'b1; in_data = 96'h10; flush = 1'b1;
      #1;
      check("fl_rdy_ungated", {95'b0, rdy_s}, 96'd1);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("fl_in_cnt", {80'b0, cnt_s}, 96'd4);
      check("fl_in_data", dat_s, BUBBLE);

      // Flush while the output entry is delivered -> no drop
      push(96'h11);
      in_valid = 1'b0;
      out_ready = 1'b1; flush = 1'b1;
      #1;
      check("fl_fire_out", {95'b0, vld_s} << 95 | dat_s, (96'd1 << 95) | 96'h11);
      tick();
      flush = 1'b0;
      check("fl_fire_cnt", {80'b0, cnt_s}, 96'd4);
      check("fl_fire_vld", {95'b0, vld_s}, 96'd0);

      // Asynchronous reset mid-cycle with both entries full
      out_ready = 1'b0;
      push(96'h12);
      push(96'h13);
      in_valid = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      check("arst_vld", {95'b0, vld_s}, 96'd0);
      check("arst_data", dat_s, BUBBLE);
      check("arst_rdy", {95'b0, rdy_s}, 96'd1);
      check("arst_cnt", {80'b0, cnt_s}, 96'd0);
      #2;
      rst = 1'b0;
      tick();

      // Saturation on the CNT_W=2 instance: three flushes of 2 entries each
      for (int r = 0; r < 3; r++) begin
         out_ready = 1'b0;
         push(96'h20 + 96'(r));
         push(96'h30 + 96'(r));
         in_valid = 1'b0; flush = 1'b1;
         tick();
         flush = 1'b0;
         check("sat_cnt", {94'b0, cnt_c}, (r == 0) ? 96'd2 : 96'd3);
         check("sat_wide_cnt", {80'b0, cnt_s}, 96'(2 * (r + 1)));
      end
      tick();
      check("sat_hold", {94'b0, cnt_c}, 96'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
